// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: opcodes, FSM
// state encoding, datapath select encodings and the control-vector layout.
package cu_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/cu_out_decode.sv
// Combinational control-vector decode from FSM state; mem_ready only
// qualifies the fetch writes and the store completion pulse.
module cu_out_decode
    import cu_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_a = SRCA_PC;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_ALU_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_BRANCH: begin
                // zero-gating of pc_write_cond happens in the datapath
                ctrl_o.alu_src_a     = SRCA_RS1;
                ctrl_o.alu_src_b     = SRCB_RS2;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = 1'b1;
                ctrl_o.instr_done    = 1'b1;
            end
            S_TRAP: ctrl_o.illegal = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Main control FSM of the multi-cycle core: state register, next-state logic
// and retired-instruction counter; outputs come from cu_out_decode.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_source,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  instret_q;
    ctrl_t             ctrl, ctrl_g;

    cu_out_decode u_dec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_BRANCH: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl.instr_done) instret_q <= instret_q + 1'b1;
        end
    end

    // Reset forces every output low, counter included, regardless of state.
    assign ctrl_g        = rst ? '0 : ctrl;
    assign mem_read      = ctrl_g.mem_read;
    assign mem_write     = ctrl_g.mem_write;
    assign iord          = ctrl_g.iord;
    assign ir_write      = ctrl_g.ir_write;
    assign pc_write      = ctrl_g.pc_write;
    assign pc_write_cond = ctrl_g.pc_write_cond;
    assign reg_write     = ctrl_g.reg_write;
    assign mem_to_reg    = ctrl_g.mem_to_reg;
    assign pc_source     = ctrl_g.pc_source;
    assign alu_src_a     = ctrl_g.alu_src_a;
    assign alu_src_b     = ctrl_g.alu_src_b;
    assign alu_op        = ctrl_g.alu_op;
    assign instr_done    = ctrl_g.instr_done;
    assign illegal       = ctrl_g.illegal;
    assign instret       = rst ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench: the driver walks each instruction through its per-step
// control table and queues the expected outputs; a monitor checks each cycle.
module tb_multicycle_cu;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_source;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
        logic [3:0] instret;
    } vec_t;

    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic       reg_write, mem_to_reg, pc_source, instr_done, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic [3:0] instret;

    vec_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cnt = 0;
    int   cyc = 0;

    multicycle_cu #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        vec_t a, e;
        cyc++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = '{mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                  reg_write, mem_to_reg, pc_source, alu_src_a, alu_src_b, alu_op,
                  instr_done, illegal, instret};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL ctrl_vec cycle=%0d got=%h exp=%h", cyc, a, e);
            end
        end
    end

    // Expected control vector for each named step of the spec's state table.
    function automatic vec_t v_fetch(input bit rdy);
        vec_t v = '0;
        v.mem_read = 1; v.src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy;
        return v;
    endfunction
    function automatic vec_t v_decode();
        vec_t v = '0; v.src_a = 2'b10; v.src_b = 2'b10; return v;
    endfunction
    function automatic vec_t v_exec(input bit rtype);
        vec_t v = '0;
        v.src_a = 2'b01;
        v.src_b = rtype ? 2'b00 : 2'b10;
        v.alu_op = rtype ? 2'b10 : 2'b00;
        return v;
    endfunction
    function automatic vec_t v_wb(input bit from_mem);
        vec_t v = '0; v.reg_write = 1; v.mem_to_reg = from_mem; v.instr_done = 1; return v;
    endfunction
    function automatic vec_t v_mem(input bit wr, input bit rdy);
        vec_t v = '0;
        v.iord = 1; v.mem_read = !wr; v.mem_write = wr; v.instr_done = wr && rdy;
        return v;
    endfunction
    function automatic vec_t v_branch();
        vec_t v = '0;
        v.src_a = 2'b01; v.alu_op = 2'b01; v.pc_write_cond = 1; v.pc_source = 1; v.instr_done = 1;
        return v;
    endfunction
    function automatic vec_t v_trap();
        vec_t v = '0; v.illegal = 1; return v;
    endfunction

    function automatic logic [6:0] rnd7();
        return 7'($urandom);
    endfunction
    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic step(input bit r, input logic [6:0] op, input bit rdy, input bit z, input vec_t e);
        @(posedge clk);
        #1;
        rst = r; opcode = op; mem_ready = rdy; zero = z;
        if (r) begin
            e = '0;
            cnt = 0;
        end else begin
            e.instret = 4'(cnt);
            if (e.instr_done) cnt = (cnt + 1) % 16;
        end
        expq.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, rnd7(), rb(), rb(), '0);
    endtask

    // abort_at >= 0: assert reset in that memory wait cycle instead of finishing
    task automatic do_instr(input int kind, input int wf, input int wm, input bit z, input int abort_at);
        logic [6:0] op;
        case (kind)
            K_R:     op = 7'b0110011;
            K_ADDI:  op = 7'b0010011;
            K_LW:    op = 7'b0000011;
            K_SW:    op = 7'b0100011;
            K_BEQ:   op = 7'b1100011;
            default: begin
                op = 7'b1111111;
                if (rb()) begin
                    op = rnd7();
                    while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
                           op == 7'b0100011 || op == 7'b1100011) op = rnd7();
                end
            end
        endcase
        for (int i = 0; i < wf; i++) step(0, rnd7(), 0, rb(), v_fetch(0));
        step(0, rnd7(), 1, rb(), v_fetch(1));
        step(0, op, rb(), rb(), v_decode());
        case (kind)
            K_R, K_ADDI: begin
                step(0, rnd7(), rb(), rb(), v_exec(kind == K_R));
                step(0, rnd7(), rb(), rb(), v_wb(0));
            end
            K_LW, K_SW: begin
                step(0, op, rb(), rb(), v_exec(0));
                for (int i = 0; i < wm; i++) begin
                    if (i == abort_at) begin
                        do_reset(1 + int'($urandom_range(0, 2)));
                        return;
                    end
                    step(0, rnd7(), 0, rb(), v_mem(kind == K_SW, 0));
                end
                step(0, rnd7(), 1, rb(), v_mem(kind == K_SW, 1));
                if (kind == K_LW) step(0, rnd7(), rb(), rb(), v_wb(1));
            end
            K_BEQ: step(0, rnd7(), rb(), z, v_branch());
            default: begin
                for (int i = 0; i < 20; i++) step(0, rnd7(), rb(), rb(), v_trap());
                do_reset(1 + int'($urandom_range(0, 2)));
            end
        endcase
    endtask

    initial begin
        int kind, wm, ab;
        do_reset(3);
        do_instr(K_R, 0, 0, 0, -1);
        do_instr(K_LW, 0, 3, 0, -1);
        do_instr(K_BEQ, 0, 0, 0, -1);
        do_instr(K_BEQ, 0, 0, 1, -1);
        do_instr(K_ILL, 0, 0, 0, -1);
        do_instr(K_SW, 0, 3, 0, 2);
        for (int i = 0; i < 17; i++) do_instr(K_ADDI, 0, 0, 0, -1);
        do_instr(K_SW, 1, 0, 0, -1);
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 4));
            if ($urandom_range(0, 24) == 0) kind = K_ILL;
            wm = int'($urandom_range(0, 3));
            ab = -1;
            if (wm > 0 && $urandom_range(0, 9) == 0) ab = int'($urandom_range(0, wm - 1));
            do_instr(kind, int'($urandom_range(0, 3)), wm, rb(), ab);
        end
        repeat (3) @(posedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d exp=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
